// File: rtl/rv_hazard_ctrl.sv
// Hazard and bypass controller for the FlexRV32 pipeline.
// Resolves ALU1 operand bypass across NUM_BP later stages, detects load-use
// and long-latency (mul/div) read-after-write hazards for the instruction in
// decode, stretches redirect flushes over FLUSH_HOLD cycles and tracks the
// unsupported-instruction flag down to its commit point.
module rv_hazard_ctrl #(
   parameter int NUM_RS     = 2,
   parameter int NUM_BP     = 4,
   parameter int LOAD_READY = 1,
   parameter int MAX_PEND   = 4,
   parameter int FLUSH_HOLD = 1,
   parameter int INV_DEPTH  = 2
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_pc_change,
   input  logic                     i_decode_inst_sup,
   input  logic [NUM_RS*5-1:0]      i_decode_rs,
   input  logic [NUM_RS*5-1:0]      i_alu1_rs,
   input  logic [4:0]               i_alu1_rd,
   input  logic                     i_alu1_mem_rd,
   input  logic [NUM_BP*5-1:0]      i_bp_rd,
   input  logic [NUM_BP-1:0]        i_bp_reg_write,
   input  logic [NUM_BP-1:0]        i_bp_mem_rd,
   input  logic                     i_lat_issue,
   input  logic                     i_lat_done,
   input  logic [4:0]               i_lat_done_rd,
   output logic                     o_decode_flush,
   output logic                     o_decode_stall,
   output logic                     o_alu1_flush,
   output logic                     o_alu2_flush,
   output logic [NUM_RS*NUM_BP-1:0] o_bp_sel,
   output logic                     o_lat_full,
   output logic                     o_inv_inst
);

   localparam int CNT_W = $clog2(MAX_PEND + 1);
   localparam int FC_W  = (FLUSH_HOLD > 1) ? $clog2(FLUSH_HOLD) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PEND);
   localparam logic [FC_W-1:0]  FC_LOAD = FC_W'(FLUSH_HOLD - 1);

   // Scoreboard state: bit r set while a long-latency write to xr is in flight.
   // Bit 0 is kept permanently clear so x0 can never look pending.
   logic [31:0]      pend_q, pend_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [FC_W-1:0]  fcnt_q, fcnt_d;
   logic [INV_DEPTH-1:0] sup_q, sup_d;

   logic [NUM_RS*NUM_BP-1:0] bp_sel;
   logic [NUM_RS-1:0]        bp_taken;
   logic load_haz;
   logic sb_haz;
   logic full_raw;
   logic lat_accept;
   logic lat_retire;
   logic flush_active;
   logic decode_flush;
   logic decode_stall;
   logic stall_raw;

   // Load flags of stages at or past the load-ready point never stall decode.
   logic unused_mem_rd;
   assign unused_mem_rd = ^i_bp_mem_rd;

   // Priority bypass select: the youngest writing stage with a matching rd wins per port.
   always_comb begin
      bp_sel   = '0;
      bp_taken = '0;
      for (int k = 0; k < NUM_RS; k++) begin
         for (int s = 0; s < NUM_BP; s++) begin
            if (!bp_taken[k] && i_bp_reg_write[s] &&
                (i_alu1_rs[5*k +: 5] != 5'd0) &&
                (i_alu1_rs[5*k +: 5] == i_bp_rd[5*s +: 5])) begin
               bp_sel[NUM_BP*k + s] = 1'b1;
               bp_taken[k]          = 1'b1;
            end
         end
      end
   end

   // Decode-side hazards: loads whose data is not yet bypassable, and pending long-latency writes.
   always_comb begin
      load_haz = 1'b0;
      sb_haz   = 1'b0;
      for (int k = 0; k < NUM_RS; k++) begin
         if (i_decode_rs[5*k +: 5] != 5'd0) begin
            if (i_alu1_mem_rd && (i_decode_rs[5*k +: 5] == i_alu1_rd)) begin
               load_haz = 1'b1;
            end
            for (int s = 0; (s < LOAD_READY) && (s < NUM_BP); s++) begin
               if (i_bp_mem_rd[s] && (i_decode_rs[5*k +: 5] == i_bp_rd[5*s +: 5])) begin
                  load_haz = 1'b1;
               end
            end
            if (pend_q[i_decode_rs[5*k +: 5]]) begin
               sb_haz = 1'b1;
            end
         end
      end
   end

   assign full_raw   = (cnt_q == CNT_MAX);
   // A redirect squashes the op in ALU1, so its issue must not be recorded.
   assign lat_accept = i_lat_issue & ~i_pc_change & (i_alu1_rd != 5'd0) & ~full_raw;
   // Completions for registers not marked pending (e.g. issued before a reset) are ignored.
   assign lat_retire = i_lat_done & pend_q[i_lat_done_rd];

   // Scoreboard update: retire clears first so a same-rd issue leaves the bit set.
   always_comb begin
      pend_d = pend_q;
      if (lat_retire) begin
         pend_d[i_lat_done_rd] = 1'b0;
      end
      if (lat_accept) begin
         pend_d[i_alu1_rd] = 1'b1;
      end
      pend_d[0] = 1'b0;
      case ({lat_accept, lat_retire})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Flush hold counter: every redirect restarts the hold window.
   always_comb begin
      fcnt_d = fcnt_q;
      if (i_pc_change) begin
         fcnt_d = FC_LOAD;
      end else if (fcnt_q != '0) begin
         fcnt_d = fcnt_q - FC_W'(1);
      end
   end

   assign flush_active = i_pc_change | (fcnt_q != '0);
   assign stall_raw    = load_haz | sb_haz | (full_raw & i_lat_issue);
   // Flushing discards decode anyway, so a stall during flush would only waste a cycle.
   assign decode_flush = flush_active | i_reset;
   assign decode_stall = stall_raw & ~flush_active & ~i_reset;

   // Supported-instruction tracker: flush refills with valid, stall freezes the pipe.
   always_comb begin
      sup_d = sup_q;
      if (decode_flush) begin
         sup_d = '1;
      end else if (!decode_stall) begin
         sup_d[0] = i_decode_inst_sup;
         for (int i = 1; i < INV_DEPTH; i++) begin
            sup_d[i] = sup_q[i-1];
         end
      end
   end

   // State registers with synchronous reset; a reset discards all outstanding ops.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         pend_q <= '0;
         cnt_q  <= '0;
         fcnt_q <= '0;
         sup_q  <= '1;
      end else begin
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
         fcnt_q <= fcnt_d;
         sup_q  <= sup_d;
      end
   end

   assign o_decode_flush = decode_flush;
   assign o_decode_stall = decode_stall;
   assign o_alu1_flush   = decode_flush | decode_stall;
   assign o_alu2_flush   = i_pc_change | i_reset;
   assign o_bp_sel       = i_reset ? '0 : bp_sel;
   assign o_lat_full     = full_raw & ~i_reset;
   assign o_inv_inst     = ~sup_q[INV_DEPTH-1] & ~i_reset;

endmodule

// File: doc/rv_hazard_ctrl.md
Name: rv_hazard_ctrl

Overview:
- Parametrised hazard and bypass controller for the FlexRV32 pipeline.
- Generalises operand bypass to NUM_RS read ports and NUM_BP stages, with lowest index taking priority.
- Adds a configurable load-ready point and a scoreboard for long-latency writebacks (mul/div).
- Adds a multi-cycle flush hold and a depth-parametrised invalid-instruction tracker.
- Sits beside decode/ALU1 and drives stall, flush and bypass-select signals into the datapath.

Parameters:
- NUM_RS, 2, number of source-register read ports per instruction (1..3).
- NUM_BP, 4, number of bypass stages after ALU1; index 0 is youngest (alu2), 3 is wr_back.
- LOAD_READY, 1, first bypass index at which load data is valid; loads in stages below this index cause a stall.
- MAX_PEND, 4, maximum outstanding long-latency writes (1..31).
- FLUSH_HOLD, 1, number of cycles o_decode_flush stays asserted per PC change (≥1).
- INV_DEPTH, 2, pipeline distance of the unsupported-instruction flag (≥1).

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous reset, active-high.
- i_pc_change  in  1  branch/jump redirect this cycle.
- i_decode_inst_sup  in  1  decode stage holds a supported instruction.
- i_decode_rs  in  NUM_RS*5  decode source registers; port k occupies bits [5k+4:5k].
- i_alu1_rs  in  NUM_RS*5  ALU1 source registers.
- i_alu1_rd  in  5  ALU1 destination register.
- i_alu1_mem_rd  in  1  ALU1 holds a load.
- i_bp_rd  in  NUM_BP*5  destination register per bypass stage.
- i_bp_reg_write  in  NUM_BP  stage writes its rd.
- i_bp_mem_rd  in  NUM_BP  stage holds a load.
- i_lat_issue  in  1  ALU1 launches a long-latency op targeting i_alu1_rd.
- i_lat_done  in  1  long-latency unit completes.
- i_lat_done_rd  in  5  destination register of the completing op.
- o_decode_flush  out  1  flush decode.
- o_decode_stall  out  1  hold decode/fetch.
- o_alu1_flush  out  1  inject a bubble into ALU1.
- o_alu2_flush  out  1  flush alu2.
- o_bp_sel  out  NUM_RS*NUM_BP  one-hot bypass select per ALU1 port; port k occupies [NUM_BP*k +: NUM_BP].
- o_lat_full  out  1  scoreboard holds MAX_PEND entries.
- o_inv_inst  out  1  invalid instruction reached its commit point.

Behaviour:
- Bypass (combinational):
  - hit[k][s] = i_bp_reg_write[s] & (rs_k != 0) & (rs_k == i_bp_rd[s]).
  - o_bp_sel[k][s] = hit[k][s] & no hit[k][j] for any j<s.
  - A port with rs=0 never selects a stage.
- Load-use hazard: asserted when any decode rs_k != 0 matches either:
  - i_alu1_rd while i_alu1_mem_rd, or
  - i_bp_rd[s] with i_bp_mem_rd[s], for any s < LOAD_READY.
- Scoreboard:
  - pend[31:1] bitmap plus a 0..MAX_PEND counter.
  - Issue is accepted when i_lat_issue & !i_pc_change & (i_alu1_rd != 0) & !o_lat_full. Accept sets pend[rd] and increments the counter.
  - i_lat_done clears pend[i_lat_done_rd] and decrements the counter only if that bit was set; otherwise the done is ignored.
  - Issue and done on the same rd in the same cycle: the bit stays set and the counter is unchanged.
  - Issue and done on different rds: both apply and the counter is unchanged.
  - Scoreboard hazard: any decode rs_k != 0 with pend[rs_k] = 1.
- o_lat_full = (count == MAX_PEND). An issue attempted while full is dropped; the upstream stalls on o_lat_full.
- o_decode_stall = load-use hazard | scoreboard hazard | (i_alu1_mem_rd... not included) | (o_lat_full & i_lat_issue).
- Flush hold:
  - Counter fcnt is loaded with FLUSH_HOLD-1 on i_pc_change (a new change restarts it) and decrements to 0.
  - o_decode_flush = i_pc_change | (fcnt != 0).
  - o_alu2_flush = i_pc_change.
  - o_alu1_flush = o_decode_flush | o_decode_stall.
  - During flush, o_decode_stall is forced to 0 (flush has priority).
- Inst-sup shift register sup[INV_DEPTH-1:0]:
  - On flush it loads all ones.
  - Else if not stalled, it shifts in i_decode_inst_sup at bit 0.
  - When stalled it holds.
  - o_inv_inst = !sup[INV_DEPTH-1].
- Reset (synchronous, in the cycle i_reset is sampled):
  - pend = 0, count = 0, fcnt = 0, sup = all ones.
  - While i_reset is high: o_decode_flush = 1, o_alu1_flush = 1, o_alu2_flush = 1, o_decode_stall = 0, o_bp_sel = 0, o_inv_inst = 0, o_lat_full = 0.
  - A reset during outstanding ops discards them; late i_lat_done pulses are ignored.

Test Plan:
- Priority bypass: ALU1 rs1 = x5; stages 1 and 3 write x5 -> o_bp_sel port0 = 4'b0010. Set rs1 = x0 -> 4'b0000.
- Load-use: ALU1 load rd = x7, decode rs2 = x7 -> decode_stall = 1 and alu1_flush = 1 for 1 cycle. With LOAD_READY = 1 and the load in stage 0, stall persists one more cycle, then clears.
- Scoreboard: issue div x9 -> stall while decode reads x9 until i_lat_done rd = x9, then stall = 0 the next cycle. Four issues with MAX_PEND = 4 -> o_lat_full = 1; a fifth issue is dropped.
- Simultaneous: issue x3 and done x3 in the same cycle -> pend[3] = 1 and count unchanged. Done x4 never issued -> no change.
- Flush hold: FLUSH_HOLD = 3, pulse i_pc_change -> o_decode_flush high for 3 cycles. A second pulse in cycle 2 extends it to cycle 4. o_alu2_flush is high only on the pulse cycles.
- Invalid instruction: INV_DEPTH = 2, i_decode_inst_sup = 0 for one non-stalled cycle -> o_inv_inst = 1 exactly 2 cycles later. A flush in between suppresses it.
